// File: rtl/spram_pixel_fetch_pkg.sv
// Shared types and constants for the SRAM pixel prefetcher.
package spram_pixel_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  // Value shown on the pixel bus whenever no fetched pixel is delivered.
  localparam int unsigned PIX_BLACK = 0;

  // Index width for a power-of-two storage array, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spram_pixel_fetch_if.sv
// Frame-store read port plus pixel delivery port of the prefetcher.
interface spram_pixel_fetch_if #(
  parameter int unsigned AW = 19,
  parameter int unsigned DW = 12
) ();

  logic          frame_start;
  logic          spram_rd_sig;
  logic          sram_rd;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_rdata;
  logic [DW-1:0] pix_data;
  logic          pix_valid;
  logic          underflow;

  modport master (
    input  frame_start, spram_rd_sig, sram_rdata,
    output sram_rd, sram_addr, pix_data, pix_valid, underflow
  );

  modport slave (
    output frame_start, spram_rd_sig, sram_rdata,
    input  sram_rd, sram_addr, pix_data, pix_valid, underflow
  );

endinterface

// File: rtl/spram_pixel_fetch_sync_fifo.sv
// Small synchronous FIFO with a registered head read; the read register shows
// IDLE_DATA in every cycle that did not follow a pop.
module sync_fifo
  import spram_pixel_fetch_pkg::*;
#(
  parameter int unsigned   DW        = 12,
  parameter int unsigned   DEPTH     = 4,
  parameter logic [DW-1:0] IDLE_DATA = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [DW-1:0]          wdata,
  output logic [DW-1:0]          rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int unsigned IW = idx_w(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic          do_push;
  logic          do_pop;
  logic [CW-1:0] count_nxt;

  // Flush overrides both ports; a pop only sees entries pushed in earlier cycles.
  always_comb begin
    do_push   = push && !flush;
    do_pop    = pop && !flush && !empty;
    count_nxt = count;
    if (flush) begin
      count_nxt = '0;
    end else if (do_push && !do_pop) begin
      count_nxt = count + CW'(1);
    end else if (!do_push && do_pop) begin
      count_nxt = count - CW'(1);
    end
  end

  // Pointers, occupancy flags and the head read register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx <= '0;
      rd_idx <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      rdata  <= IDLE_DATA;
    end else begin
      if (flush) begin
        wr_idx <= '0;
        rd_idx <= '0;
      end else begin
        if (do_push) wr_idx <= wr_idx + IW'(1);
        if (do_pop)  rd_idx <= rd_idx + IW'(1);
      end
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == CW'(DEPTH));
      rdata <= do_pop ? mem[rd_idx] : IDLE_DATA;
    end
  end

  // Storage array.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_idx] <= wdata;
  end

endmodule

// File: rtl/spram_pixel_fetch.sv
// Prefetching pixel reader: walks the frame store linearly after each frame
// start and keeps a small FIFO topped up so VGA can pull one pixel per cycle.
module spram_pixel_fetch
  import spram_pixel_fetch_pkg::*;
#(
  parameter int unsigned W      = 640,
  parameter int unsigned H      = 480,
  parameter int unsigned AW     = 19,
  parameter int unsigned DW     = 12,
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned DEPTH  = 4
) (
  input logic               clk,
  input logic               rst,
  spram_pixel_fetch_if.master bus
);

  localparam int unsigned TOTAL = W * H;
  localparam int unsigned PW    = AW + 1;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam int unsigned LW    = $clog2(DEPTH + RD_LAT + 2) + 1;

  state_e            state;
  state_e            state_nxt;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     rd_base_c;
  logic [RD_LAT-1:0] inflight;
  logic              sram_rd_q;
  logic [AW-1:0]     sram_addr_q;
  logic              pix_valid_q;
  logic              underflow_q;
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic [DW-1:0]     fifo_rdata;
  logic              issue_c;
  logic              pop_c;
  logic              push_c;
  logic [LW-1:0]     outstanding_c;
  logic [LW-1:0]     level_c;
  logic [LW-1:0]     level_pop_c;

  assign bus.sram_rd   = sram_rd_q;
  assign bus.sram_addr = sram_addr_q;
  assign bus.pix_data  = fifo_rdata;
  assign bus.pix_valid = pix_valid_q;
  assign bus.underflow = underflow_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; a frame start restarts the walk from any state.
  always_comb begin
    state_nxt = state;
    if (bus.frame_start) begin
      state_nxt = ST_FILL;
    end else begin
      case (state)
        ST_FILL: begin
          if (rd_ptr == PW'(TOTAL))           state_nxt = ST_DRAIN;
          else if (level_c == LW'(DEPTH))     state_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (rd_ptr == PW'(TOTAL))           state_nxt = ST_DRAIN;
        end
        default: ;
      endcase
    end
  end

  // Issue/pop/push decisions. Outstanding reads (strobe on the bus plus the
  // in-flight pipe) are reserved FIFO slots, and a pop this cycle frees one,
  // which is what lets the refill keep pace with one pixel per cycle.
  always_comb begin
    outstanding_c = LW'(sram_rd_q);
    for (int i = 0; i < int'(RD_LAT); i++) begin
      outstanding_c = outstanding_c + LW'(inflight[i]);
    end
    pop_c       = bus.spram_rd_sig && !fifo_empty && !bus.frame_start;
    push_c      = inflight[RD_LAT-1];
    level_c     = LW'(fifo_count) + outstanding_c;
    level_pop_c = level_c - LW'(pop_c);
    rd_base_c   = bus.frame_start ? '0 : rd_ptr;
    issue_c     = 1'b0;
    if (bus.frame_start) begin
      issue_c = 1'b1;
    end else if ((state == ST_FILL) || (state == ST_RUN)) begin
      issue_c = (rd_ptr < PW'(TOTAL)) && (level_pop_c < LW'(DEPTH));
    end
  end

  // Read strobe/address, in-flight tracking and pixel-side status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr      <= '0;
      sram_rd_q   <= 1'b0;
      sram_addr_q <= '0;
      inflight    <= '0;
      pix_valid_q <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      sram_rd_q <= issue_c;
      if (issue_c) begin
        sram_addr_q <= AW'(rd_base_c);
        rd_ptr      <= rd_base_c + PW'(1);
      end else begin
        rd_ptr <= rd_base_c;
      end
      inflight    <= bus.frame_start ? '0 : RD_LAT'({inflight, sram_rd_q});
      pix_valid_q <= pop_c;
      if (bus.frame_start) begin
        underflow_q <= 1'b0;
      end else if (bus.spram_rd_sig && fifo_empty) begin
        underflow_q <= 1'b1;
      end
    end
  end

  // Pixel FIFO; a frame start flushes it.
  sync_fifo #(
    .DW        (DW),
    .DEPTH     (DEPTH),
    .IDLE_DATA (DW'(PIX_BLACK))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .pop   (pop_c),
    .flush (bus.frame_start),
    .wdata (bus.sram_rdata),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // The issue rule reserves a slot for every outstanding read.
  a_no_push_full: assert property (@(posedge clk) disable iff (rst)
    !(push_c && fifo_full && !bus.frame_start));

endmodule

// File: tb/tb_spram_pixel_fetch.sv
// Vector-table bench for spram_pixel_fetch with an addr+0x100 SRAM model.
module tb_spram_pixel_fetch;
  import spram_pixel_fetch_pkg::*;

  localparam int unsigned W      = 5;
  localparam int unsigned H      = 4;
  localparam int unsigned AW     = 19;
  localparam int unsigned DW     = 12;
  localparam int unsigned RD_LAT = 2;
  localparam int unsigned DEPTH  = 4;

  typedef struct {
    int          sc;
    int          k;
    logic        r;
    logic        fs;
    logic        req;
    logic        ev;
    logic [11:0] ed;
    logic        eu;
    logic        crd;
    logic        erd;
    logic        cad;
    int          eaddr;
    logic        ccnt;
    int          ecnt;
    logic        cst;
    state_e      est;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   vec_cnt = 0;
  int   err_cnt = 0;
  vec_t v;
  vec_t e;
  vec_t vq[$];
  vec_t sb[$];

  logic [AW-1:0] a_d1;
  logic          v_d1;

  spram_pixel_fetch_if #(.AW(AW), .DW(DW)) bus ();

  spram_pixel_fetch #(
    .W(W), .H(H), .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .DEPTH(DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // SRAM model: data = addr + 0x100, valid two cycles after the strobe.
  always @(posedge clk) begin
    a_d1 <= bus.sram_addr;
    v_d1 <= bus.sram_rd;
    bus.sram_rdata <= v_d1 ? (DW'(a_d1) + 12'h100) : 12'hEEE;
  end

  task automatic chk(input int sc, input int k, input string nm,
                     input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL s%0d k%0d %s: got 0x%0h want 0x%0h", sc, k, nm, act, exp);
    end
  endtask

  task automatic mk(input int sc, input int k, input logic r, input logic fs,
                    input logic req, input logic ev, input logic [11:0] ed,
                    input logic eu);
    v.sc = sc; v.k = k; v.r = r; v.fs = fs; v.req = req;
    v.ev = ev; v.ed = ed; v.eu = eu;
    v.crd = 1'b0; v.erd = 1'b0; v.cad = 1'b0; v.eaddr = 0;
    v.ccnt = 1'b0; v.ecnt = 0; v.cst = 1'b0; v.est = ST_IDLE;
  endtask

  task automatic rd_exp(input logic erd, input int addr);
    v.crd = 1'b1; v.erd = erd;
    v.cad = erd; v.eaddr = addr;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.frame_start  = 1'b0;
    bus.spram_rd_sig = 1'b0;

    // Reset values, then idle with no reads.
    for (int i = 0; i < 3; i++) begin
      mk(0, i, 1'b1, 1'b0, 1'b0, 1'b0, 12'h0, 1'b0);
      rd_exp(1'b0, 0); v.cad = 1'b1;
      v.cst = 1'b1; v.est = ST_IDLE; v.ccnt = 1'b1; v.ecnt = 0;
      vq.push_back(v);
    end
    for (int i = 0; i < 6; i++) begin
      mk(0, 3 + i, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 1'b0);
      rd_exp(1'b0, 0); v.cst = 1'b1; v.est = ST_IDLE;
      vq.push_back(v);
    end

    // Frame 1: fill, 20-pixel stream, then one request too many.
    for (int k = 0; k < 45; k++) begin
      mk(1, k, 1'b0, k == 0, (k >= 20) && (k <= 40), (k >= 20) && (k < 40),
         ((k >= 20) && (k < 40)) ? 12'(256 + k - 20) : 12'h000, k >= 40);
      if (k <= 3)                 rd_exp(1'b1, k);
      else if (k < 20 || k > 40)  rd_exp(1'b0, 0);
      if (k >= 3 && k < 20) begin
        v.ccnt = 1'b1; v.ecnt = (k < 6) ? k - 2 : 4;
      end
      if (k == 0)              begin v.cst = 1'b1; v.est = ST_FILL;  end
      if (k >= 6 && k < 20)    begin v.cst = 1'b1; v.est = ST_RUN;   end
      if (k == 39 || k == 44)  begin v.cst = 1'b1; v.est = ST_DRAIN; end
      vq.push_back(v);
    end

    // Frame 2: request right after frame start underflows; first pixel survives.
    for (int k = 0; k < 15; k++) begin
      mk(2, k, 1'b0, k == 0, (k == 1) || (k == 12) || (k == 13),
         (k == 12) || (k == 13),
         (k == 12) ? 12'h100 : ((k == 13) ? 12'h101 : 12'h000), k >= 1);
      if (k == 0) begin rd_exp(1'b1, 0); v.cst = 1'b1; v.est = ST_FILL; end
      if (k == 6) begin v.ccnt = 1'b1; v.ecnt = 4; end
      vq.push_back(v);
    end

    // Frame 3: restart with two reads in flight, then frame_start with a request.
    for (int k = 0; k < 31; k++) begin
      mk(3, k, 1'b0, (k == 0) || (k == 2) || (k == 18),
         ((k >= 14) && (k <= 18)) || (k == 29),
         ((k >= 14) && (k <= 17)) || (k == 29),
         ((k >= 14) && (k <= 17)) ? 12'(256 + k - 14) :
           ((k == 29) ? 12'h100 : 12'h000),
         1'b0);
      if (k == 0 || k == 2 || k == 18) rd_exp(1'b1, 0);
      if (k == 1)                      rd_exp(1'b1, 1);
      if (k >= 3 && k <= 5)            rd_exp(1'b1, k - 2);
      if (k == 6)                      rd_exp(1'b0, 0);
      if (k >= 3 && k <= 8) begin v.ccnt = 1'b1; v.ecnt = (k < 5) ? 0 : k - 4; end
      if (k == 2 || k == 18) begin v.cst = 1'b1; v.est = ST_FILL; end
      vq.push_back(v);
    end

    // Frame 4: reset in the middle of the stream.
    for (int k = 0; k < 27; k++) begin
      mk(4, k, k == 16, k == 0, (k >= 12) && (k <= 16), (k >= 12) && (k <= 15),
         ((k >= 12) && (k <= 15)) ? 12'(256 + k - 12) : 12'h000, 1'b0);
      if (k >= 16) begin
        rd_exp(1'b0, 0); v.cad = 1'b1;
        v.cst = 1'b1; v.est = ST_IDLE; v.ccnt = 1'b1; v.ecnt = 0;
      end
      vq.push_back(v);
    end

    @(posedge clk); #1;
    for (int i = 0; i < vq.size(); i++) begin
      rst              = vq[i].r;
      bus.frame_start  = vq[i].fs;
      bus.spram_rd_sig = vq[i].req;
      sb.push_back(vq[i]);
      @(posedge clk); #1;
      if (sb.size() == 0) begin
        vec_cnt++; err_cnt++;
        $display("FAIL scoreboard: no expectation queued at vector %0d", i);
      end else begin
        e = sb.pop_front();
        chk(e.sc, e.k, "pix_valid", 32'(bus.pix_valid), 32'(e.ev));
        chk(e.sc, e.k, "pix_data",  32'(bus.pix_data),  32'(e.ed));
        chk(e.sc, e.k, "underflow", 32'(bus.underflow), 32'(e.eu));
        if (e.crd)  chk(e.sc, e.k, "sram_rd",    32'(bus.sram_rd),        32'(e.erd));
        if (e.cad)  chk(e.sc, e.k, "sram_addr",  32'(bus.sram_addr),      32'(e.eaddr));
        if (e.ccnt) chk(e.sc, e.k, "fifo_count", 32'(dut.u_fifo.count),   32'(e.ecnt));
        if (e.cst)  chk(e.sc, e.k, "state",      32'(dut.state),          32'(e.est));
      end
    end

    rst              = 1'b0;
    bus.frame_start  = 1'b0;
    bus.spram_rd_sig = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
